// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
// Optional build macro: MULDIV_EARLY_OUT_EN (multiply early exit).
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_RUN,
    S_DIV_RUN,
    S_DONE
  } muldiv_state_t;

  function automatic logic is_signed_a(input muldiv_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input muldiv_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_sign_fixup.sv
// Sign restoration of the magnitude result and selection of the
// product half, quotient or remainder requested by the operation.
module muldiv_sign_fixup
  import muldiv_pkg::*;
#(
  parameter int W = 32
) (
  input  muldiv_op_t     op_i,
  input  logic           neg_a_i,
  input  logic           neg_b_i,
  input  logic           fast_i,
  input  logic [2*W-1:0] prod_i,
  input  logic [W-1:0]   quot_i,
  input  logic [W-1:0]   rem_i,
  output logic [W-1:0]   result_o
);

  logic           neg_res;
  logic           neg_rem;
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quot_s;
  logic [W-1:0]   rem_s;

  // Fast-path results are already final and must not be negated.
  assign neg_res = (neg_a_i ^ neg_b_i) & ~fast_i;
  assign neg_rem = neg_a_i & ~fast_i;

  assign prod_s = neg_res ? -prod_i : prod_i;
  assign quot_s = neg_res ? -quot_i : quot_i;
  assign rem_s  = neg_rem ? -rem_i  : rem_i;

  always_comb begin
    result_o = rem_s;
    unique case (op_i)
      OP_MUL:                      result_o = prod_s[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_o = prod_s[2*W-1:W];
      OP_DIV, OP_DIVU:             result_o = quot_s;
      default:                     result_o = rem_s;
    endcase
  end

endmodule

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit beside the execute-stage ALU.
// Define MULDIV_EARLY_OUT_EN to let multiplies exit once b is exhausted.
module execute_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [ADDR_WIDTH-1:0] rd_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [ADDR_WIDTH-1:0] rd_o
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  muldiv_state_t         state_q;
  muldiv_op_t            op_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  neg_a_q;
  logic                  neg_b_q;
  logic                  fast_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [2*W-1:0]        acc_q;
  logic [2*W-1:0]        mcand_q;
  logic [W-1:0]          mplr_q;
  logic [W-1:0]          dvsr_q;
  logic [W-1:0]          rem_q;

  muldiv_op_t     op_in;
  logic           sa;
  logic           sb;
  logic [W-1:0]   abs_a;
  logic [W-1:0]   abs_b;
  logic           div_zero;
  logic           div_ovf;
  logic           launch;
  logic [2*W-1:0] mul_acc_d;
  logic [W-1:0]   mplr_d;
  logic           mul_last;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic           div_ge;
  logic [W-1:0]   fix_res;

  assign op_in = muldiv_op_t'(op_i);
  assign sa    = is_signed_a(op_in) & a_i[W-1];
  assign sb    = is_signed_b(op_in) & b_i[W-1];
  assign abs_a = sa ? -a_i : a_i;
  assign abs_b = sb ? -b_i : b_i;

  assign div_zero = ~|b_i;
  assign div_ovf  = (op_in == OP_DIV || op_in == OP_REM)
                  && a_i == MIN_NEG && &b_i;

  assign launch = reset & (state_q == S_IDLE) & start_i & ~flush_i;

  assign mul_acc_d = acc_q + (mplr_q[0] ? mcand_q : '0);
  assign mplr_d    = mplr_q >> 1;

`ifdef MULDIV_EARLY_OUT_EN
  assign mul_last = ~|mplr_d;
`else
  assign mul_last = (cnt_q == CNT_WIDTH'(1));
`endif

  // Restoring step: shift in the next dividend bit, trial-subtract.
  assign div_shift = {rem_q, mplr_q[W-1]};
  assign div_diff  = div_shift - {1'b0, dvsr_q};
  assign div_ge    = ~div_diff[W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      rd_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      fast_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      dvsr_q  <= '0;
      rem_q   <= '0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_q    <= op_in;
            rd_q    <= rd_i;
            neg_a_q <= sa;
            neg_b_q <= sb;
            fast_q  <= 1'b0;
            cnt_q   <= CNT_WIDTH'(DATA_WIDTH);
            acc_q   <= '0;
            mcand_q <= {{W{1'b0}}, abs_a};
            dvsr_q  <= abs_b;
            rem_q   <= '0;
            unique case (1'b1)
              !op_i[2]: begin
                mplr_q  <= abs_b;
                state_q <= S_MUL_RUN;
              end
              div_zero: begin
                mplr_q  <= '1;
                rem_q   <= a_i;
                fast_q  <= 1'b1;
                state_q <= S_DONE;
              end
              div_ovf: begin
                mplr_q  <= MIN_NEG;
                fast_q  <= 1'b1;
                state_q <= S_DONE;
              end
              default: begin
                mplr_q  <= abs_a;
                state_q <= S_DIV_RUN;
              end
            endcase
          end
        end
        S_MUL_RUN: begin
          acc_q   <= mul_acc_d;
          mcand_q <= mcand_q << 1;
          mplr_q  <= mplr_d;
          cnt_q   <= cnt_q - CNT_WIDTH'(1);
          if (mul_last) state_q <= S_DONE;
        end
        S_DIV_RUN: begin
          rem_q  <= div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
          mplr_q <= {mplr_q[W-2:0], div_ge};
          cnt_q  <= cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) state_q <= S_DONE;
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  muldiv_sign_fixup #(
    .W (W)
  ) u_fixup (
    .op_i     (op_q),
    .neg_a_i  (neg_a_q),
    .neg_b_i  (neg_b_q),
    .fast_i   (fast_q),
    .prod_i   (acc_q),
    .quot_i   (mplr_q),
    .rem_i    (rem_q),
    .result_o (fix_res)
  );

  assign busy_o   = (state_q != S_IDLE);
  assign stall_o  = launch | (state_q == S_MUL_RUN)
                  | (state_q == S_DIV_RUN);
  assign done_o   = (state_q == S_DONE) & ~flush_i;
  assign result_o = done_o ? fix_res : '0;
  assign rd_o     = rd_q;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Directed bench for execute_muldiv_unit at DATA_WIDTH=32.
// Default build: fixed multiply latency.
module tb_execute_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start_i = 1'b0;
  logic [2:0]   op_i = 3'd0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic [4:0]   rd_i = '0;
  logic         flush_i = 1'b0;
  logic         busy_o;
  logic         stall_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic [4:0]   rd_o;

  int total = 0;
  int passed = 0;

  execute_muldiv_unit #(
    .DATA_WIDTH (W),
    .ADDR_WIDTH (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .rd_i     (rd_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o),
    .rd_o     (rd_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=0x%08h expected=0x%08h",
                tag, obs, exp);
  endtask

  task automatic wait_done(output int n, output int st);
    n = 0;
    st = 0;
    while (done_o !== 1'b1 && n < 100) begin
      if (stall_o === 1'b1) st = st + 1;
      @(posedge clk);
      #1;
      n = n + 1;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] rd, input logic [W-1:0] exp,
                        input int lat);
    int n;
    int st;
    @(negedge clk);
    op_i = op;
    a_i = a;
    b_i = b;
    rd_i = rd;
    start_i = 1'b1;
    #1;
    chk({tag, "_launch_stall"}, W'(stall_o), 1);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    a_i = '0;
    b_i = '0;
    rd_i = '0;
    wait_done(n, st);
    chk({tag, "_latency"}, W'(n), W'(lat));
    chk({tag, "_stall_cycles"}, W'(st + 1), W'(lat + 1));
    chk({tag, "_result"}, result_o, exp);
    chk({tag, "_rd"}, W'(rd_o), W'(rd));
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, W'(done_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int st;
    int dones;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", W'(busy_o), 0);
    chk("rst_stall", W'(stall_o), 0);
    chk("rst_done", W'(done_o), 0);
    chk("rst_result", result_o, 0);
    chk("rst_rd", W'(rd_o), 0);
    @(negedge clk);
    reset = 1'b1;

    run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 32);
    run_op("mulhu", 3'b011, '1, '1, 5'd4, 32'hFFFF_FFFE, 32);
    run_op("mulh", 3'b001, '1, '1, 5'd5, 32'h0000_0000, 32);
    run_op("mulhsu", 3'b010, '1, 32'd2, 5'd6, 32'hFFFF_FFFF, 32);
    run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 32);
    run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 32);
    run_op("divu", 3'b101, 32'd100, 32'd7, 5'd9, 32'd14, 32);
    run_op("remu", 3'b111, 32'd100, 32'd7, 5'd10, 32'd2, 32);
    run_op("div0", 3'b100, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 0);
    run_op("rem0", 3'b110, 32'd5, 32'd0, 5'd12, 32'd5, 0);
    run_op("ovf_div", 3'b100, 32'h8000_0000, '1, 5'd13, 32'h8000_0000, 0);
    run_op("ovf_rem", 3'b110, 32'h8000_0000, '1, 5'd14, 32'd0, 0);

    // Flush during a divide.
    @(negedge clk);
    op_i = 3'b100;
    a_i = 32'hFFFF_FFF9;
    b_i = 32'd2;
    rd_i = 5'd15;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush_i = 1'b1;
    chk("flush_run_done", W'(done_o), 0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    chk("flush_busy", W'(busy_o), 0);
    chk("flush_stall", W'(stall_o), 0);
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done_o === 1'b1) dones = dones + 1;
    end
    chk("flush_no_done", W'(dones), 0);
    run_op("after_flush", 3'b101, 32'd100, 32'd7, 5'd16, 32'd14, 32);

    // Flush arriving while the result is presented.
    @(negedge clk);
    op_i = 3'b000;
    a_i = 32'd7;
    b_i = 32'hFFFF_FFFD;
    rd_i = 5'd17;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done(n, st);
    chk("fdone_reached", W'(done_o), 1);
    flush_i = 1'b1;
    #1;
    chk("fdone_done", W'(done_o), 0);
    chk("fdone_result", result_o, 0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    chk("fdone_busy", W'(busy_o), 0);

    // Asynchronous reset mid-multiply.
    @(negedge clk);
    op_i = 3'b000;
    a_i = 32'd7;
    b_i = 32'd5;
    rd_i = 5'd18;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", W'(busy_o), 1);
    reset = 1'b0;
    #1;
    chk("arst_busy", W'(busy_o), 0);
    chk("arst_stall", W'(stall_o), 0);
    chk("arst_done", W'(done_o), 0);
    chk("arst_result", result_o, 0);
    chk("arst_rd", W'(rd_o), 0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done_o === 1'b1) dones = dones + 1;
    end
    chk("arst_no_done", W'(dones), 0);

    // start_i held high across a whole operation.
    @(negedge clk);
    op_i = 3'b101;
    a_i = 32'd100;
    b_i = 32'd7;
    rd_i = 5'd19;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    wait_done(n, st);
    chk("hold_latency", W'(n), 32);
    chk("hold_result", result_o, 32'd14);
    a_i = 32'd50;
    @(posedge clk);
    #1;
    chk("hold_done_ignored", W'(busy_o), 0);
    chk("hold_idle_launch", W'(stall_o), 1);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("hold_accept", W'(busy_o), 1);
    wait_done(n, st);
    chk("hold2_latency", W'(n), 32);
    chk("hold2_result", result_o, 32'd7);
    @(posedge clk);
    #1;
    chk("hold2_done_pulse", W'(done_o), 0);
    chk("hold2_idle", W'(busy_o), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
